// File: rtl/regfile_scoreboard_pkg.sv
// Shared core constants for the register file and its scoreboard.
package regfile_scoreboard_pkg;

  localparam int CORE_XLEN  = 32;
  localparam int CORE_NREGS = 32;
  localparam int REG_ZERO   = 0;

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_busy.sv
// Scoreboard busy bits: one pending-producer flag per architectural register.
module regfile_sb_busy
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS = CORE_NREGS,
  localparam int AW = calc_aw(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_q
);

  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a new producer wins over a retiring one;
  // addresses outside the register range never match any entry.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (clr_en && clr_addr == AW'(r)) busy_d[r] = 1'b0;
      if (set_en && set_addr == AW'(r)) busy_d[r] = 1'b1;
    end
    if (flush) busy_d = '0;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass and a scoreboard that flags
// RAW/WAW hazards so the issue stage can stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int NREGS = CORE_NREGS,
  parameter int NRD   = 2,
  localparam int AW = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  input  logic [NRD-1:0]      rs_re,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                rd_we,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_data_from_wb,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NRD-1:0]   src_in_range;
  logic             iss_busy;
  logic             waw;
  logic             set_en;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      if (rd_we && r != REG_ZERO && rd_addr == AW'(r)) regs_d[r] = rd_data_from_wb;
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  // Reads are forced to zero during reset so a pending writeback cannot
  // leak through the bypass path.
  always_comb begin
    rs_data      = '0;
    rs_busy      = '0;
    src_in_range = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rs_re[i] && !reset) begin
        for (int r = 0; r < NREGS; r++) begin
          if (rs_addr[i*AW +: AW] == AW'(r)) begin
            src_in_range[i]            = 1'b1;
            rs_data[i*XLEN +: XLEN]    = regs_q[r];
            rs_busy[i]                 = busy_q[r];
          end
        end
        if (rd_we && rd_addr == rs_addr[i*AW +: AW]) begin
          rs_busy[i] = 1'b0;
          if (src_in_range[i] && rs_addr[i*AW +: AW] != AW'(REG_ZERO))
            rs_data[i*XLEN +: XLEN] = rd_data_from_wb;
        end
      end
    end
  end

  always_comb begin
    iss_busy = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (iss_rd == AW'(r)) iss_busy = busy_q[r];
    end
    waw    = iss_busy && iss_rd != AW'(REG_ZERO) && !(rd_we && rd_addr == iss_rd);
    stall  = iss_valid && ((|rs_busy) || waw);
    set_en = iss_valid && !stall && !flush && iss_rd != AW'(REG_ZERO);
  end

  regfile_sb_busy #(.NREGS(NREGS)) u_busy (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (iss_rd),
    .clr_en   (rd_we),
    .clr_addr (rd_addr),
    .flush    (flush),
    .busy_q   (busy_q)
  );

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                reset;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD-1:0]      rs_re;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                rd_we;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     rd_data_from_wb;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic                stall;
  logic [NREGS-1:0]    busy_vec;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk             (clk),
    .reset           (reset),
    .rs_addr         (rs_addr),
    .rs_re           (rs_re),
    .rs_data         (rs_data),
    .rs_busy         (rs_busy),
    .rd_we           (rd_we),
    .rd_addr         (rd_addr),
    .rd_data_from_wb (rd_data_from_wb),
    .iss_valid       (iss_valid),
    .iss_rd          (iss_rd),
    .flush           (flush),
    .stall           (stall),
    .busy_vec        (busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    rs_addr = '0; rs_re = '0; rd_we = 1'b0; rd_addr = '0;
    rd_data_from_wb = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rd_we = 1'b1; rd_addr = 5'd5; rd_data_from_wb = 32'h1111_2222;
    rs_re = 2'b11; rs_addr = {5'd5, 5'd5};
    iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    total++;
    if (busy_vec !== '0) begin bad++; $display("[TB] FAIL reset_busy got=%h exp=0", busy_vec); end
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
    total++;
    if (rs_data !== '0) begin bad++; $display("[TB] FAIL reset_rsdata got=%h exp=0", rs_data); end
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    rd_we = 1'b1; rd_addr = 5'd5; rd_data_from_wb = 32'hDEAD_BEEF;
    step();
    idle();
    rs_re = 2'b01; rs_addr = {5'd0, 5'd5};
    #1;
    total++;
    if (rs_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL read_x5 got=%h exp=deadbeef", rs_data[31:0]); end
    rd_we = 1'b1; rd_addr = 5'd0; rd_data_from_wb = 32'h0000_1234;
    rs_addr = {5'd0, 5'd0};
    #1;
    total++;
    if (rs_data[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL bypass_x0 got=%h exp=0", rs_data[31:0]); end
    step();
    idle();
    rs_re = 2'b01; rs_addr = {5'd0, 5'd0};
    #1;
    total++;
    if (rs_data[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL read_x0 got=%h exp=0", rs_data[31:0]); end
  endtask

  task automatic test_bypass();
    idle();
    rd_we = 1'b1; rd_addr = 5'd7; rd_data_from_wb = 32'hA5A5_A5A5;
    rs_re = 2'b11; rs_addr = {5'd7, 5'd5};
    #1;
    total++;
    if (rs_data[63:32] !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL bypass_p1 got=%h exp=a5a5a5a5", rs_data[63:32]); end
    total++;
    if (rs_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL bypass_p0 got=%h exp=deadbeef", rs_data[31:0]); end
    rs_re = 2'b00;
    #1;
    total++;
    if (rs_data !== '0) begin bad++; $display("[TB] FAIL re_off got=%h exp=0", rs_data); end
    step();
    idle();
    rs_re = 2'b10; rs_addr = {5'd7, 5'd0};
    #1;
    total++;
    if (rs_data[63:32] !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL read_x7 got=%h exp=a5a5a5a5", rs_data[63:32]); end
  endtask

  task automatic test_raw();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL raw_first_stall got=%b exp=0", stall); end
    step();
    iss_valid = 1'b1; iss_rd = 5'd10; rs_re = 2'b01; rs_addr = {5'd0, 5'd3};
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("[TB] FAIL raw_stall got=%b exp=1", stall); end
    total++;
    if (rs_busy !== 2'b01) begin bad++; $display("[TB] FAIL raw_rsbusy got=%b exp=01", rs_busy); end
    step();
    total++;
    if (busy_vec !== 32'h0000_0008) begin bad++; $display("[TB] FAIL raw_held got=%h exp=00000008", busy_vec); end
    rd_we = 1'b1; rd_addr = 5'd3; rd_data_from_wb = 32'h0000_0033;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL raw_resolved_stall got=%b exp=0", stall); end
    total++;
    if (rs_busy !== 2'b00) begin bad++; $display("[TB] FAIL raw_resolved_rsbusy got=%b exp=00", rs_busy); end
    step();
    total++;
    if (busy_vec !== 32'h0000_0400) begin bad++; $display("[TB] FAIL raw_after got=%h exp=00000400", busy_vec); end
    idle();
    rd_we = 1'b1; rd_addr = 5'd10; rd_data_from_wb = 32'h0000_00AA;
    step();
    total++;
    if (busy_vec !== '0) begin bad++; $display("[TB] FAIL raw_drain got=%h exp=0", busy_vec); end
  endtask

  task automatic test_same_cycle();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    rd_we = 1'b1; rd_addr = 5'd9; rd_data_from_wb = 32'h0000_0099;
    step();
    total++;
    if (busy_vec !== 32'h0000_0200) begin bad++; $display("[TB] FAIL set_prio got=%h exp=00000200", busy_vec); end
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("[TB] FAIL waw_stall got=%b exp=1", stall); end
    step();
    total++;
    if (busy_vec !== 32'h0000_0200) begin bad++; $display("[TB] FAIL waw_held got=%h exp=00000200", busy_vec); end
  endtask

  task automatic test_flush();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd4;
    step();
    iss_rd = 5'd6;
    step();
    total++;
    if (busy_vec !== 32'h0000_0250) begin bad++; $display("[TB] FAIL pre_flush got=%h exp=00000250", busy_vec); end
    iss_rd = 5'd8; flush = 1'b1;
    step();
    total++;
    if (busy_vec !== '0) begin bad++; $display("[TB] FAIL flush got=%h exp=0", busy_vec); end
  endtask

  task automatic test_zero_and_idle_wb();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL x0_issue_stall got=%b exp=0", stall); end
    step();
    idle();
    rd_we = 1'b1; rd_addr = 5'd12; rd_data_from_wb = 32'hCAFE_F00D;
    step();
    total++;
    if (busy_vec !== '0) begin bad++; $display("[TB] FAIL nonbusy_wb got=%h exp=0", busy_vec); end
    idle();
    rs_re = 2'b10; rs_addr = {5'd12, 5'd0};
    #1;
    total++;
    if (rs_data[63:32] !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL read_x12 got=%h exp=cafef00d", rs_data[63:32]); end
  endtask

  task automatic test_reset_mid();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd2;
    step();
    total++;
    if (busy_vec !== 32'h0000_0004) begin bad++; $display("[TB] FAIL pre_reset_busy got=%h exp=00000004", busy_vec); end
    idle();
    rd_we = 1'b1; rd_addr = 5'd11; rd_data_from_wb = 32'h0000_0055;
    rs_re = 2'b11; rs_addr = {5'd5, 5'd11};
    iss_valid = 1'b1; iss_rd = 5'd2;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (busy_vec !== '0) begin bad++; $display("[TB] FAIL midreset_busy got=%h exp=0", busy_vec); end
    total++;
    if (rs_data !== '0) begin bad++; $display("[TB] FAIL midreset_rsdata got=%h exp=0", rs_data); end
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stall got=%b exp=0", stall); end
    step();
    reset = 1'b0;
    idle();
    rs_re = 2'b11; rs_addr = {5'd5, 5'd11};
    #1;
    total++;
    if (rs_data[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL lost_write got=%h exp=0", rs_data[31:0]); end
    total++;
    if (rs_data[63:32] !== 32'h0) begin bad++; $display("[TB] FAIL cleared_x5 got=%h exp=0", rs_data[63:32]); end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_raw();
    test_same_cycle();
    test_flush();
    test_zero_and_idle_wb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
